// File: rtl/reg_write_arbiter_pkg.sv
// Shared state type and default sizing for the register-file write arbiter.
package regarb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arb_state_t;

  localparam int REGARB_NREQ = 3;
  localparam int REGARB_DW   = 8;
  localparam int REGARB_AW   = 3;

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// Round-robin grant logic: one-hot combinational grant, searched from the
// requester after the last one granted; the pointer moves only on a grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] idx;

  // Walk the search order backwards so the nearest requester overwrites last.
  always_comb begin
    grant = '0;
    idx   = '0;
    if (en) begin
      for (int k = N; k >= 1; k--) begin
        idx = PW'((int'(last_q) + k) % N);
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PW'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) last_q <= PW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Write-port controller for the register file: round-robin arbitration plus an
// optional bulk clear, built only when REGARB_CLEAR_EN is defined.
module reg_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NREQ  = REGARB_NREQ,
  parameter int DW    = REGARB_DW,
  parameter int AW    = REGARB_AW,
  parameter int NREGS = 2 ** AW
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_ACK,
  input  logic              CLEAR_START,
  output logic              CLEAR_BUSY,
  output logic              WRITE,
  output logic [AW-1:0]     INADDRESS,
  output logic [DW-1:0]     IN
);

  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  assign REQ_ACK = grant;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (CLK),
    .rst   (RESET),
    .en    (arb_en),
    .req   (REQ_VALID),
    .grant (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = REQ_ADDR[i*AW +: AW];
        sel_data = REQ_DATA[i*DW +: DW];
      end
    end
  end

`ifdef REGARB_CLEAR_EN
  arb_state_t    state;
  logic [AW-1:0] cnt;

  // A clear request pre-empts arbitration in the cycle it arrives.
  assign arb_en     = (state == ARB_IDLE) && !CLEAR_START;
  assign CLEAR_BUSY = (state == ARB_CLEAR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else begin
      WRITE <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (CLEAR_START) begin
            state <= ARB_CLEAR;
            cnt   <= '0;
          end else if (|grant) begin
            WRITE     <= 1'b1;
            INADDRESS <= sel_addr;
            IN        <= sel_data;
          end
        end
        ARB_CLEAR: begin
          WRITE     <= 1'b1;
          INADDRESS <= cnt;
          IN        <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == AW'(NREGS - 1)) state <= ARB_IDLE;
        end
      endcase
    end
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = CLEAR_START;
  assign arb_en             = 1'b1;
  assign CLEAR_BUSY         = 1'b0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else begin
      WRITE <= |grant;
      if (|grant) begin
        INADDRESS <= sel_addr;
        IN        <= sel_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter; expectations follow REGARB_CLEAR_EN.
module tb_reg_write_arbiter;

  localparam int NREQ  = 3;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NREGS = 8;
`ifdef REGARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RESET;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                clear_start;
  logic [NREQ-1:0]     req_ack;
  logic                clear_busy;
  logic                write;
  logic [AW-1:0]       inaddress;
  logic [DW-1:0]       in_data;

  int errors = 0;
  int checks = 0;

  // Reference model: pointer, remaining clear steps, and the command visible on the port.
  int            m_last;
  int            m_left;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NREGS(NREGS)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ_VALID   (req_valid),
    .REQ_ADDR    (req_addr),
    .REQ_DATA    (req_data),
    .REQ_ACK     (req_ack),
    .CLEAR_START (clear_start),
    .CLEAR_BUSY  (clear_busy),
    .WRITE       (write),
    .INADDRESS   (inaddress),
    .IN          (in_data)
  );

  always #5 CLK = ~CLK;

  function automatic int winner();
    if (m_left > 0 || (CLEAR_EN && clear_start)) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ack();
    logic [NREQ-1:0] a;
    int w;
    a = '0;
    w = winner();
    if (w >= 0) a[w] = 1'b1;
    return a;
  endfunction

  task automatic tick();
    int w;
    @(posedge CLK);
    w = winner();
    if (RESET) begin
      m_last = NREQ - 1; m_left = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_left > 0) begin
      m_wr = 1'b1; m_addr = AW'(NREGS - m_left); m_data = '0; m_left--;
    end else if (CLEAR_EN && clear_start) begin
      m_wr = 1'b0; m_left = NREGS;
    end else if (w >= 0) begin
      m_wr = 1'b1; m_addr = req_addr[w*AW +: AW]; m_data = req_data[w*DW +: DW]; m_last = w;
    end else begin
      m_wr = 1'b0;
    end
    #1;
  endtask

  task automatic rand_req(input int i);
    req_addr[i*AW +: AW] = AW'($urandom_range(NREGS - 1));
    req_data[i*DW +: DW] = DW'($urandom_range(255));
  endtask

  task automatic do_reset();
    RESET = 1'b1; req_valid = '0; clear_start = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
    tick(); tick();
    #3; checks++;
    if ({req_ack, write, inaddress, in_data, clear_busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b wr=%b addr=%0d in=%h busy=%b, expected all zero",
               req_ack, write, inaddress, in_data, clear_busy);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b001; req_addr[0 +: AW] = 3'd3; req_data[0 +: DW] = 8'hA5;
    #3; checks++;
    if (req_ack !== 3'b001) begin
      errors++; $display("FAIL single_ack: ack=%b expected 001", req_ack);
    end
    tick();
    req_valid = '0;
    #3; checks++;
    if ({write, inaddress, in_data} !== {1'b1, 3'd3, 8'hA5}) begin
      errors++; $display("FAIL single_write: wr=%b addr=%0d in=%h expected wr=1 addr=3 in=a5",
                         write, inaddress, in_data);
    end
    tick();
    #3; checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL single_idle: wr=%b expected 0", write);
    end
    tick();
  endtask

  task automatic test_all_valid();
    logic [NREQ-1:0] acked;
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #3; checks++;
      if (req_ack !== NREQ'(1 << (c % NREQ))) begin
        errors++; $display("FAIL all_valid_order c=%0d: ack=%b expected %b", c, req_ack, NREQ'(1 << (c % NREQ)));
      end
      checks++;
      if ({req_ack, write, inaddress, in_data} !== {exp_ack(), m_wr, m_addr, m_data}) begin
        errors++; $display("FAIL all_valid_model c=%0d: ack=%b wr=%b addr=%0d in=%h expected ack=%b wr=%b addr=%0d in=%h",
                           c, req_ack, write, inaddress, in_data, exp_ack(), m_wr, m_addr, m_data);
      end
      acked = exp_ack();
      tick();
      for (int i = 0; i < NREQ; i++) if (acked[i]) rand_req(i);
    end
    req_valid = '0;
    #3; checks++;
    if ({write, inaddress, in_data} !== {m_wr, m_addr, m_data} || write !== 1'b1) begin
      errors++; $display("FAIL all_valid_tail: wr=%b addr=%0d in=%h expected wr=1 addr=%0d in=%h",
                         write, inaddress, in_data, m_addr, m_data);
    end
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 3'b100; rand_req(0); rand_req(2);
    #3; checks++;
    if (req_ack !== 3'b100) begin errors++; $display("FAIL rotation_first: ack=%b expected 100", req_ack); end
    tick();
    req_valid = 3'b101; rand_req(2);
    #3; checks++;
    if (req_ack !== 3'b001) begin errors++; $display("FAIL rotation_wrap: ack=%b expected 001", req_ack); end
    tick();
    req_valid = 3'b100;
    #3; checks++;
    if (req_ack !== 3'b100) begin errors++; $display("FAIL rotation_next: ack=%b expected 100", req_ack); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_clear();
    int zero_writes = 0;
    int ack_cycle = -1;
    logic [NREQ-1:0] acked;
    do_reset();
    req_valid = 3'b010; req_addr[1*AW +: AW] = 3'd6; req_data[1*DW +: DW] = 8'h5A;
    clear_start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #3; checks++;
      if ({req_ack, write, inaddress, in_data, clear_busy} !== {exp_ack(), m_wr, m_addr, m_data, m_left > 0}) begin
        errors++; $display("FAIL clear_model c=%0d: ack=%b wr=%b addr=%0d in=%h busy=%b expected ack=%b wr=%b addr=%0d in=%h busy=%b",
                           c, req_ack, write, inaddress, in_data, clear_busy, exp_ack(), m_wr, m_addr, m_data, m_left > 0);
      end
      if (write && in_data == 8'h00) begin
        checks++;
        if (inaddress !== AW'(zero_writes)) begin
          errors++; $display("FAIL clear_order: addr=%0d expected %0d", inaddress, zero_writes);
        end
        zero_writes++;
      end
      if (req_ack[1] && ack_cycle < 0) ack_cycle = c;
      acked = exp_ack();
      tick();
      clear_start = 1'b0;
      if (acked[1]) req_valid[1] = 1'b0;
    end
    checks++;
    if (zero_writes != (CLEAR_EN ? NREGS : 0)) begin
      errors++; $display("FAIL clear_count: zero_writes=%0d expected %0d", zero_writes, CLEAR_EN ? NREGS : 0);
    end
    checks++;
    if (ack_cycle != (CLEAR_EN ? NREGS + 1 : 0)) begin
      errors++; $display("FAIL clear_ack_cycle: cycle=%0d expected %0d", ack_cycle, CLEAR_EN ? NREGS + 1 : 0);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3; checks++;
      if ({write, inaddress, in_data, clear_busy} !== {m_wr, m_addr, m_data, m_left > 0}) begin
        errors++; $display("FAIL midclear_run c=%0d: wr=%b addr=%0d in=%h busy=%b expected wr=%b addr=%0d in=%h busy=%b",
                           c, write, inaddress, in_data, clear_busy, m_wr, m_addr, m_data, m_left > 0);
      end
      tick();
    end
    RESET = 1'b1;
    #3; checks++;
    if ({write, inaddress, clear_busy} !== {m_wr, m_addr, m_left > 0}) begin
      errors++; $display("FAIL midclear_fourth: wr=%b addr=%0d busy=%b expected wr=%b addr=%0d busy=%b",
                         write, inaddress, clear_busy, m_wr, m_addr, m_left > 0);
    end
    tick();
    RESET = 1'b0;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    req_valid = '1;
    #3; checks++;
    if ({write, clear_busy, req_ack} !== {1'b0, 1'b0, 3'b001}) begin
      errors++; $display("FAIL midclear_after_reset: wr=%b busy=%b ack=%b expected wr=0 busy=0 ack=001",
                         write, clear_busy, req_ack);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acked;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RESET       = ($urandom_range(59) == 0);
      clear_start = ($urandom_range(24) == 0);
      #3; checks++;
      if ({req_ack, write, inaddress, in_data, clear_busy} !== {exp_ack(), m_wr, m_addr, m_data, m_left > 0}) begin
        errors++; $display("FAIL random c=%0d: ack=%b wr=%b addr=%0d in=%h busy=%b expected ack=%b wr=%b addr=%0d in=%h busy=%b",
                           c, req_ack, write, inaddress, in_data, clear_busy, exp_ack(), m_wr, m_addr, m_data, m_left > 0);
      end
      acked = exp_ack();
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acked[i]) begin
          req_valid[i] = 1'($urandom_range(1));
          rand_req(i);
        end
      end
    end
    RESET = 1'b0; clear_start = 1'b0; req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_rotation();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
